// File: rtl/regfile_8x32_if.sv
// Register-file access bus: one write port, two read ports and the
// written-since-reset map. The master drives the addresses and write data, and the slave
// (the register file) returns the read data.
interface regfile_8x32_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_writeEnable;
  logic [2:0]       ctrl_writeReg;
  logic [WIDTH-1:0] data_writeReg;
  logic [2:0]       ctrl_readRegA;
  logic [2:0]       ctrl_readRegB;
  logic [WIDTH-1:0] data_readRegA;
  logic [WIDTH-1:0] data_readRegB;
  logic [7:0]       written_map;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB, written_map
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB, written_map
  );
endinterface

// File: rtl/regfile_8x32.sv
// 8-entry register file with one write port and two combinational read ports.
// r0 is hard-wired to zero. Reads return the pre-edge contents, with no bypass.
// written_map records which of r1..r7 have been written since reset.
module regfile_8x32 #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           ctrl_reset_n,
  regfile_8x32_if.slave  bus
);

  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       written_q;
  logic [7:0]       written_d;

  // One-hot write select decoded from the write address and the global strobe.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    wr_sel = '0;
    if (bus.ctrl_writeEnable) begin
      wr_sel[bus.ctrl_writeReg] = 1'b1;
    end
  end

  // Next-state contents: load the selected register, except r0, which never loads.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 8; i++) begin
      if (wr_sel[i]) begin
        regs_d[i] = bus.data_writeReg;
      end
    end
  end

  // Next-state written map: accumulate accepted writes; bit 0 is kept clear.
  always_comb begin
    written_d = (written_q | wr_sel) & 8'hFE;
  end

  // State registers. The asynchronous clear wipes every entry immediately.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      // NOTE: this storage is reset on purpose, because reads must return zero during and after reset.
      regs_q    <= '{default: '0};
      written_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so reads see pre-edge values.
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end

  // Port-A read mux, forcing zero for r0.
  always_comb begin
    bus.data_readRegA = '0;
    if (bus.ctrl_readRegA != 3'd0) begin
      bus.data_readRegA = regs_q[bus.ctrl_readRegA];
    end
  end

  // Port-B read mux, forcing zero for r0.
  always_comb begin
    bus.data_readRegB = '0;
    if (bus.ctrl_readRegB != 3'd0) begin
      bus.data_readRegB = regs_q[bus.ctrl_readRegB];
    end
  end

  assign bus.written_map = written_q;

endmodule
